// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: data width, instruction size and loader states.
package mips_pkg;

   localparam int WORD_W          = 32;
   localparam int BYTES_PER_INSTR = 4;
   localparam int ADDR_SHIFT      = $clog2(BYTES_PER_INSTR);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      RUN,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up counter with synchronous clear that sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!resetN || clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams PROG_LEN words into instruction memory, then releases the core.
// Optional XOR checksum gate on release: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int PROG_LEN = 2,
   parameter int WORD_W   = mips_pkg::WORD_W,
   parameter int CYC_W    = 16
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              start,
   input  logic              srcValid,
   input  logic [WORD_W-1:0] srcData,
   output logic              srcReady,
   input  logic [WORD_W-1:0] expectedSum,
   output logic [WORD_W-1:0] instrIn,
   output logic [WORD_W-1:0] instrAddr,
   output logic              instrWrite,
   output logic              instrRead,
   output logic              pcReset,
   output logic              pcWrite,
   output logic              initializing,
   output logic              done,
   output logic              error,
   output logic [CYC_W-1:0]  cycleNo
);

   import mips_pkg::*;

   localparam int                IDX_W    = $clog2(PROG_LEN + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PROG_LEN - 1);

   loader_state_t    state;
   logic [IDX_W-1:0] wIdx;
   logic             accept;
   logic             sumOk;

   // Stream handshake: a word transfers on an edge where srcValid && srcReady.
   // srcReady is registered and only high in LOAD; srcData must hold while srcValid waits.
   assign accept = srcValid && srcReady;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] runSum;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         runSum <= '0;
      end else if ((state == IDLE) && start) begin
         runSum <= '0;
      end else if (accept) begin
         runSum <= runSum ^ srcData;
      end
   end

   assign sumOk = (runSum == expectedSum);
`else
   logic unusedSum;

   assign unusedSum = ^expectedSum;
   assign sumOk     = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state        <= IDLE;
         srcReady     <= 1'b0;
         instrWrite   <= 1'b0;
         instrRead    <= 1'b0;
         pcWrite      <= 1'b0;
         pcReset      <= 1'b1;
         initializing <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         instrIn      <= '0;
         instrAddr    <= '0;
         wIdx         <= '0;
      end else begin
         instrWrite <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  srcReady <= 1'b1;
                  wIdx     <= '0;
               end
            end
            LOAD: begin
               if (accept) begin
                  instrWrite <= 1'b1;
                  instrIn    <= srcData;
                  instrAddr  <= WORD_W'(wIdx) << ADDR_SHIFT;
                  wIdx       <= wIdx + IDX_W'(1);
                  // Last word: its write lands in SETTLE while ready drops.
                  if (wIdx == LAST_IDX) begin
                     state    <= SETTLE;
                     srcReady <= 1'b0;
                  end
               end
            end
            SETTLE: begin
               if (sumOk) begin
                  state        <= RUN;
                  pcReset      <= 1'b0;
                  pcWrite      <= 1'b1;
                  instrRead    <= 1'b1;
                  initializing <= 1'b0;
                  done         <= 1'b1;
               end else begin
                  state <= ERROR;
                  error <= 1'b1;
               end
            end
            RUN, ERROR: begin
            end
            default: state <= IDLE;
         endcase
      end
   end

   sat_counter #(
      .W(CYC_W)
   ) cycleCnt (
      .clk    (clk),
      .resetN (resetN),
      .clr    ((state == IDLE) && start),
      .en     (state == RUN),
      .count  (cycleNo)
   );

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a phase-level behavioural model checked every cycle.
module tb_program_loader;

   localparam int          PROG_LEN = 2;
   localparam logic [31:0] W0       = 32'h0000_8020;
   localparam logic [31:0] W1       = 32'h0210_8020;
   localparam logic [31:0] GOOD_SUM = 32'h0210_0000;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam logic CK_EN = 1'b1;
`else
   localparam logic CK_EN = 1'b0;
`endif

   localparam int P_IDLE = 0, P_LOAD = 1, P_SETTLE = 2, P_RUN = 3, P_ERR = 4;

   logic        clk = 1'b0;
   logic        resetN, start, srcValid;
   logic [31:0] srcData, expectedSum;

   logic        srcReady, instrWrite, instrRead, pcReset, pcWrite, initializing, done, error;
   logic [31:0] instrIn, instrAddr;
   logic [15:0] cycleNo;
   logic        srcReady4, instrWrite4, instrRead4, pcReset4, pcWrite4, initializing4, done4, error4;
   logic [31:0] instrIn4, instrAddr4;
   logic [3:0]  cycleNo4;

   int          nChecks = 0;
   int          nFail   = 0;
   logic        cmpEn   = 1'b0;
   logic [63:0] got_q[$];

   int          mPhase, mIdx, eRun;
   logic [31:0] mSum, eIn, eAddr;
   logic        eWrite;

   program_loader #(.PROG_LEN(PROG_LEN), .WORD_W(32), .CYC_W(16)) dut (
      .clk(clk), .resetN(resetN), .start(start), .srcValid(srcValid), .srcData(srcData),
      .srcReady(srcReady), .expectedSum(expectedSum), .instrIn(instrIn), .instrAddr(instrAddr),
      .instrWrite(instrWrite), .instrRead(instrRead), .pcReset(pcReset), .pcWrite(pcWrite),
      .initializing(initializing), .done(done), .error(error), .cycleNo(cycleNo)
   );

   program_loader #(.PROG_LEN(PROG_LEN), .WORD_W(32), .CYC_W(4)) dut4 (
      .clk(clk), .resetN(resetN), .start(start), .srcValid(srcValid), .srcData(srcData),
      .srcReady(srcReady4), .expectedSum(expectedSum), .instrIn(instrIn4), .instrAddr(instrAddr4),
      .instrWrite(instrWrite4), .instrRead(instrRead4), .pcReset(pcReset4), .pcWrite(pcWrite4),
      .initializing(initializing4), .done(done4), .error(error4), .cycleNo(cycleNo4)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: words are written one cycle after acceptance at index*4; after the last
   // word one settle cycle, then the core runs (or errors on a checksum miss).
   always @(posedge clk) begin
      if (!resetN) begin
         mPhase = P_IDLE; mIdx = 0; mSum = '0; eWrite = 1'b0;
         eIn = '0; eAddr = '0; eRun = 0;
      end else begin
         eWrite = 1'b0;
         case (mPhase)
            P_IDLE: if (start) begin mPhase = P_LOAD; mIdx = 0; mSum = '0; end
            P_LOAD: if (srcValid) begin
               eWrite = 1'b1; eIn = srcData; eAddr = 32'(mIdx * 4);
               mSum = mSum ^ srcData; mIdx++;
               if (mIdx == PROG_LEN) mPhase = P_SETTLE;
            end
            P_SETTLE: mPhase = (CK_EN && (mSum != expectedSum)) ? P_ERR : P_RUN;
            P_RUN: eRun++;
            default: ;
         endcase
      end
   end

   task automatic cmpAll(input string tag, input logic rdy, input logic wr, input logic rd,
                         input logic pr, input logic pw, input logic ini, input logic dn,
                         input logic er, input logic [31:0] din, input logic [31:0] adr,
                         input logic [31:0] cyc, input int cycMax);
      logic run;
      run = (mPhase == P_RUN);
      chk({tag, "_srcReady"}, rdy, mPhase == P_LOAD);
      chk({tag, "_instrWrite"}, wr, eWrite);
      chk({tag, "_instrRead"}, rd, run);
      chk({tag, "_pcReset"}, pr, !run);
      chk({tag, "_pcWrite"}, pw, run);
      chk({tag, "_initializing"}, ini, !run);
      chk({tag, "_done"}, dn, run);
      chk({tag, "_error"}, er, mPhase == P_ERR);
      chk({tag, "_cycleNo"}, cyc, (eRun > cycMax) ? cycMax : eRun);
      if (eWrite) begin
         chk({tag, "_instrIn"}, din, eIn);
         chk({tag, "_instrAddr"}, adr, eAddr);
      end
   endtask

   // scoreboard compare, every cycle away from the active edge
   always @(negedge clk) begin
      if (cmpEn) begin
         cmpAll("c16", srcReady, instrWrite, instrRead, pcReset, pcWrite, initializing, done,
                error, instrIn, instrAddr, 32'(cycleNo), 65535);
         cmpAll("c4", srcReady4, instrWrite4, instrRead4, pcReset4, pcWrite4, initializing4,
                done4, error4, instrIn4, instrAddr4, 32'(cycleNo4), 15);
         if (instrWrite) got_q.push_back({instrAddr, instrIn});
      end
   end

   // driver tasks
   task automatic doReset();
      resetN = 1'b0;
      step();
      resetN = 1'b1;
      step();
   endtask

   task automatic doLoad(input int gap);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < PROG_LEN; i++) begin
         srcValid = 1'b1;
         srcData  = (i == 0) ? W0 : W1;
         step();
         srcValid = 1'b0;
         repeat (gap) step();
      end
   endtask

   task automatic chkWrites(input string nm);
      chk({nm, "_count"}, 64'(got_q.size()), 2);
      chk({nm, "_w0"}, got_q[0], {32'h0, W0});
      chk({nm, "_w1"}, got_q[1], {32'h4, W1});
   endtask

   initial begin
      resetN = 1'b0; start = 1'b0; srcValid = 1'b0; srcData = '0; expectedSum = GOOD_SUM;
      step();
      cmpEn = 1'b1;
      step();
      @(negedge clk);
      chk("reset_pcReset", pcReset, 1);
      chk("reset_srcReady", srcReady, 0);
      chk("reset_initializing", initializing, 1);
      chk("reset_cycleNo", cycleNo, 0);
      chk("reset_instrAddr", instrAddr, 0);

      // back-to-back load
      resetN = 1'b1;
      step();
      got_q.delete();
      start = 1'b1;
      step();
      start = 1'b0; srcValid = 1'b1; srcData = W0;
      step();
      @(negedge clk);
      chk("t1_wr0", instrWrite, 1);
      chk("t1_addr0", instrAddr, 0);
      chk("t1_data0", instrIn, W0);
      srcData = W1;
      step();
      srcValid = 1'b0;
      @(negedge clk);
      chk("t1_addr1", instrAddr, 4);
      chk("t1_data1", instrIn, W1);
      chk("t1_ready_low", srcReady, 0);
      chk("t1_done_low", done, 0);
      step();
      @(negedge clk);
      chk("t1_done", done, 1);
      chk("t1_pcReset", pcReset, 0);
      chk("t1_cycle0", cycleNo, 0);

      // start pulses and srcValid while running
      srcValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         start = 1'b1;
         step();
         start = 1'b0;
         step();
      end
      srcValid = 1'b0;
      chk("t4_cycle8", cycleNo, 8);
      chkWrites("t1_writes");

      // saturation of the narrow counter
      repeat (20) step();
      chk("t5_sat15", cycleNo4, 15);
      chk("t5_cycle28", cycleNo, 28);

      // reset mid-load, srcValid in IDLE, reload
      doReset();
      got_q.delete();
      start = 1'b1;
      step();
      start = 1'b0; srcValid = 1'b1; srcData = W0;
      step();
      srcValid = 1'b0; resetN = 1'b0;
      step();
      resetN = 1'b1; srcValid = 1'b1;
      @(negedge clk);
      chk("t3_ready", srcReady, 0);
      chk("t3_pcReset", pcReset, 1);
      chk("t3_done", done, 0);
      repeat (3) step();
      chk("t3_partial_writes", 64'(got_q.size()), 1);
      srcValid = 1'b0;
      got_q.delete();
      doLoad(0);
      step();
      chkWrites("t3_reload");
      chk("t3_done", done, 1);

      // gapped source
      doReset();
      got_q.delete();
      doLoad(1);
      step();
      chkWrites("t2_gapped");
      chk("t2_done", done, 1);

      // checksum mismatch
      doReset();
      expectedSum = 32'h0;
      doLoad(0);
      step();
      @(negedge clk);
      chk("t6_error", error, CK_EN);
      chk("t6_done", done, !CK_EN);
      chk("t6_pcReset", pcReset, CK_EN);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time front end of the MIPS core; replaces the testbench `initial` loop that loads instruction memory.
- Accepts instruction words over a valid/ready stream and writes them to instruction memory at word-aligned addresses.
- Holds the PC in reset during loading, then releases the core by asserting instrRead and pcWrite and deasserting initializing.
- Counts executed cycles once the core is running.

Parameters:
PROG_LEN, 2, number of instruction words to load; legal range 1..256
WORD_W, 32, instruction and address width
CYC_W, 16, width of the cycle counter

Ports:
clk  in  1  system clock, rising edge
resetN  in  1  synchronous reset, active-low
start  in  1  single-cycle pulse that begins a load; sampled only in IDLE
srcValid  in  1  srcData holds a valid instruction word
srcData  in  WORD_W  instruction word to load
srcReady  out  1  loader accepts a word this cycle
expectedSum  in  WORD_W  expected XOR checksum; used only with the option enabled
instrIn  out  WORD_W  write data to instruction memory
instrAddr  out  WORD_W  write byte address to instruction memory
instrWrite  out  1  instruction-memory write enable
instrRead  out  1  instruction-memory read enable
pcReset  out  1  holds the PC at 0
pcWrite  out  1  PC update enable
initializing  out  1  core address-mux select: 1 selects loader address, 0 selects PC
done  out  1  program loaded and core running
error  out  1  checksum mismatch
cycleNo  out  CYC_W  cycles elapsed in RUN

Behaviour:
- Clock and reset: one clock `clk`. Reset `resetN` is synchronous and active-low. All outputs are registered.
- Reset values:
  - state = IDLE
  - srcReady = 0, instrWrite = 0, instrRead = 0, pcWrite = 0
  - pcReset = 1, initializing = 1
  - done = 0, error = 0, cycleNo = 0, instrIn = 0, instrAddr = 0
  - internal word index wIdx = 0
- States: IDLE, LOAD, SETTLE, RUN, ERROR.
- IDLE:
  - srcReady = 0; srcValid is ignored.
  - start = 1 -> LOAD, wIdx = 0.
- LOAD:
  - srcReady = 1.
  - A word is accepted on any edge where srcValid && srcReady.
  - In the following cycle: instrWrite = 1, instrIn = accepted word, instrAddr = wIdx_at_accept << 2 (zero-extended).
  - instrWrite is 0 in any cycle that follows a non-accepting edge.
  - wIdx increments on each accept.
  - The accept with wIdx == PROG_LEN-1 moves to SETTLE, and srcReady falls in that same next cycle.
  - Load latency is therefore PROG_LEN accepts plus 1 write cycle; back-to-back accepts give one write per cycle.
- SETTLE:
  - Lasts exactly 1 cycle; it carries the final write.
  - The next state is RUN, or ERROR if the option is enabled and the checksum mismatches.
- RUN:
  - pcReset = 0, pcWrite = 1, instrRead = 1, initializing = 0, done = 1, instrWrite = 0.
  - cycleNo increments every cycle and saturates at all-ones.
  - start is ignored.
  - Only resetN leaves RUN.
- ERROR:
  - pcReset = 1, initializing = 1, error = 1, done = 0.
  - The state is held until resetN.
- Reset mid-load: returns to IDLE in the next cycle and discards the partial program; memory contents already written are left as they are.
- start asserted while in LOAD, SETTLE or RUN: no effect.
- wIdx width: clog2(PROG_LEN+1). Address wrap is impossible within the legal range.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR of all accepted words is computed; it clears on the start pulse.
  - In SETTLE the running XOR is compared with expectedSum: match -> RUN, mismatch -> ERROR.
- Disabled:
  - No checksum logic is built; expectedSum is ignored.
  - error is tied to 0, and SETTLE always goes to RUN.

Decomposition:
- Shared package mips_pkg holds:
  - WORD_W
  - BYTES_PER_INSTR = 4
  - loader_state_t enum (IDLE, LOAD, SETTLE, RUN, ERROR)
- One sub-module: sat_counter, a parameterised-width enable/clear saturating counter used for cycleNo.

Test Plan:
1. Reset, then start, then words 0x00008020 and 0x02108020 streamed back-to-back -> instrWrite high for 2 cycles with addresses 0 then 4; done = 1 two cycles after the last accept; pcReset = 0.
2. Same words with srcValid gapped every other cycle -> instrWrite pulses only after accept edges; addresses are still 0 and 4; no duplicate writes.
3. resetN low for 1 cycle after the first accept -> next cycle is IDLE with pcReset = 1 and srcReady = 0; a fresh start reloads from address 0.
4. srcValid = 1 in IDLE without start, and start pulses during RUN -> no accept and no write; cycleNo keeps incrementing by 1 per cycle.
5. CYC_W = 4, run 20 cycles -> cycleNo saturates at 15.
6. PROGRAM_LOADER_CHECKSUM_EN with expectedSum = 0x02100000 (the XOR of the two words) -> RUN; with expectedSum = 0 -> ERROR, error = 1, pcReset remains 1.
